// File: rtl/frame_generator_param_pkg.sv
// Shared constants and types for the parametrised Ethernet test-frame generator.
// Register addresses, fixed preamble/SFD bytes and the run-control state type.
package frame_generator_param_pkg;

  localparam logic [7:0] ADDR_HDR_END = 8'h10;
  localparam logic [7:0] ADDR_IFG     = 8'h10;
  localparam logic [7:0] ADDR_CTRL    = 8'h11;
  localparam logic [7:0] ADDR_TARGET  = 8'h12;
  localparam logic [7:0] ADDR_PAYLOAD = 8'h13;
  localparam logic [7:0] ADDR_CKSUM0  = 8'h14;
  localparam logic [7:0] ADDR_CKSUM1  = 8'h15;
  localparam logic [7:0] ADDR_CKSUM2  = 8'h16;
  localparam logic [7:0] ADDR_CKSUM3  = 8'h17;
  localparam logic [7:0] ADDR_FRAMES  = 8'h18;
  localparam logic [7:0] ADDR_STATUS  = 8'h19;

  localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0] SFD_BYTE      = 8'hAB;

  localparam int unsigned HDR_BYTES = 24;
  localparam int unsigned HDR_REGS  = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } fg_state_t;

endpackage

// File: rtl/frame_generator_param_if.sv
// Avalon-MM register bus plus AXI-Stream egress of the frame generator.
// slave = generator view, master = host / downstream view.
interface frame_generator_param_if #(
  parameter int unsigned DATA_W = 16
);
  logic [7:0]          writedata;
  logic                write;
  logic                chipselect;
  logic [7:0]          address;
  logic                read;
  logic [7:0]          readdata;
  logic [DATA_W-1:0]   egress_port_tdata;
  logic [DATA_W/8-1:0] egress_port_tkeep;
  logic                egress_port_tlast;
  logic                egress_port_tready;
  logic                egress_port_tvalid;

  modport slave (
    input  writedata, write, chipselect, address, read, egress_port_tready,
    output readdata, egress_port_tdata, egress_port_tkeep, egress_port_tlast, egress_port_tvalid
  );

  modport master (
    output writedata, write, chipselect, address, read, egress_port_tready,
    input  readdata, egress_port_tdata, egress_port_tkeep, egress_port_tlast, egress_port_tvalid
  );
endinterface

// File: rtl/frame_generator_param_beat_packer.sv
// Builds one egress beat from the current byte index, the 24 header bytes and
// the payload bytes fetched for each lane; first byte of the beat goes in the MSB lane.
module frame_gen_beat_packer
  import frame_generator_param_pkg::*;
#(
  parameter int unsigned BPB = 2
) (
  input  logic [16:0]      i_idx,
  input  logic [16:0]      i_total,
  input  logic [7:0]       i_hdr [HDR_BYTES],
  input  logic [7:0]       i_pay [BPB],
  output logic [BPB*8-1:0] o_tdata,
  output logic [BPB-1:0]   o_tkeep,
  output logic             o_tlast
);
  logic [16:0] w_byte;

  always_comb begin
    o_tdata = '0;
    o_tkeep = '0;
    w_byte  = '0;
    for (int unsigned k = 0; k < BPB; k++) begin
      w_byte = i_idx + 17'(k);
      if (w_byte < i_total) begin
        o_tkeep[BPB-1-k] = 1'b1;
        o_tdata[(BPB-1-k)*8 +: 8] = (w_byte < 17'(HDR_BYTES)) ? i_hdr[w_byte[4:0]] : i_pay[k];
      end
    end
    o_tlast = (i_idx + 17'(BPB)) >= i_total;
  end
endmodule

// File: rtl/frame_generator_param.sv
// Avalon-MM programmed Ethernet test-frame source streaming on AXI-Stream,
// with payload buffer, shadowed header, frame-count target and status readback.
module frame_generator_param
  import frame_generator_param_pkg::*;
#(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned PAYLOAD_DEPTH = 128
) (
  input logic                   clk,
  input logic                   reset,
  frame_generator_param_if.slave bus
);
  localparam int unsigned BPB   = DATA_W / 8;
  localparam int unsigned PTR_W = $clog2(PAYLOAD_DEPTH);

  fg_state_t        r_state, w_state_next;
  logic [7:0]       r_hdr [HDR_REGS];
  logic [7:0]       r_shd [HDR_REGS];
  logic [7:0]       r_buf [PAYLOAD_DEPTH];
  logic [7:0]       r_ifg, r_shd_ifg, r_target, r_frames, r_run_cnt, r_gap, r_readdata;
  logic             r_en, r_done, r_wr_err;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [31:0]      r_cksum;
  logic [16:0]      r_idx;

  logic             w_wr, w_rd, w_busy, w_valid, w_hs, w_snap, w_frame_done, w_target_hit;
  logic [7:0]       w_run_next, w_rdata;
  logic [16:0]      w_total;
  logic [7:0]       w_hdr [HDR_BYTES];
  logic [7:0]       w_pay [BPB];
  logic [DATA_W-1:0] w_tdata;
  logic [BPB-1:0]   w_tkeep;
  logic             w_tlast;

  assign w_wr    = bus.chipselect && bus.write;
  assign w_rd    = bus.chipselect && bus.read;
  assign w_busy  = (r_state != IDLE);
  assign w_valid = (r_state == SEND);
  assign w_hs    = w_valid && bus.egress_port_tready;
  assign w_total = 17'(HDR_BYTES) + {1'b0, r_shd[13], r_shd[12]};

  // LEN goes out high byte (0x0D) first, type in address order.
  always_comb begin
    w_hdr = '{default: PREAMBLE_BYTE};
    w_hdr[7] = SFD_BYTE;
    for (int unsigned k = 0; k < 12; k++) w_hdr[8+k] = r_shd[k];
    w_hdr[20] = r_shd[13];
    w_hdr[21] = r_shd[12];
    w_hdr[22] = r_shd[14];
    w_hdr[23] = r_shd[15];
  end

  always_comb begin
    for (int unsigned k = 0; k < BPB; k++)
      w_pay[k] = r_buf[PTR_W'(r_idx + 17'(k) - 17'(HDR_BYTES))];
  end

  frame_gen_beat_packer #(.BPB(BPB)) u_packer (
    .i_idx   (r_idx),
    .i_total (w_total),
    .i_hdr   (w_hdr),
    .i_pay   (w_pay),
    .o_tdata (w_tdata),
    .o_tkeep (w_tkeep),
    .o_tlast (w_tlast)
  );

  assign bus.egress_port_tvalid = w_valid;
  assign bus.egress_port_tdata  = w_valid ? w_tdata : '0;
  assign bus.egress_port_tkeep  = w_valid ? w_tkeep : '0;
  assign bus.egress_port_tlast  = w_valid && w_tlast;
  assign bus.readdata           = r_readdata;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_snap       = 1'b0;
    w_frame_done = 1'b0;
    w_target_hit = 1'b0;
    w_run_next   = r_run_cnt + 8'd1;
    case (r_state)
      IDLE: if (r_en) begin
        w_state_next = SEND;
        w_snap       = 1'b1;
      end
      SEND: if (w_hs && w_tlast) begin
        w_frame_done = 1'b1;
        if (r_target != '0 && w_run_next == r_target) begin
          w_target_hit = 1'b1;
          w_state_next = IDLE;
        end else if (!r_en) begin
          w_state_next = IDLE;
        end else if (r_shd_ifg == '0) begin
          w_snap = 1'b1;
        end else begin
          w_state_next = GAP;
        end
      end
      GAP: if (r_gap == '0) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shd     <= '{default: '0};
      r_shd_ifg <= '0;
      r_idx     <= '0;
      r_gap     <= '0;
    end else begin
      if (w_snap) begin
        r_shd     <= r_hdr;
        r_shd_ifg <= r_ifg;
        r_idx     <= '0;
      end else if (w_hs) begin
        r_idx <= r_idx + 17'(BPB);
      end
      if (w_frame_done && w_state_next == GAP) r_gap <= r_shd_ifg - 8'd1;
      else if (r_state == GAP)                 r_gap <= r_gap - 8'd1;
    end
  end

  // Register writes are applied after frame-completion updates so CNT_CLR and EN win.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hdr     <= '{default: '0};
      r_ifg     <= '0;
      r_en      <= 1'b0;
      r_target  <= '0;
      r_wr_ptr  <= '0;
      r_cksum   <= '0;
      r_frames  <= '0;
      r_run_cnt <= '0;
      r_done    <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      if (w_frame_done) begin
        r_frames  <= r_frames + 8'd1;
        r_run_cnt <= w_run_next;
      end
      if (w_target_hit) begin
        r_done <= 1'b1;
        r_en   <= 1'b0;
      end
      if (w_wr) begin
        if (bus.address < ADDR_HDR_END) r_hdr[bus.address[3:0]] <= bus.writedata;
        case (bus.address)
          ADDR_IFG:    r_ifg <= bus.writedata;
          ADDR_CTRL: begin
            r_en <= bus.writedata[0];
            if (bus.writedata[0]) begin
              r_done <= 1'b0;
              if (!r_en) r_run_cnt <= '0;
            end
            if (bus.writedata[1]) begin
              r_wr_ptr <= '0;
              r_cksum  <= '0;
              r_wr_err <= 1'b0;
            end
            if (bus.writedata[2]) r_frames <= '0;
          end
          ADDR_TARGET: r_target <= bus.writedata;
          ADDR_PAYLOAD: begin
            if (w_busy) begin
              r_wr_err <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + PTR_W'(1);
              r_cksum  <= r_cksum + {24'b0, bus.writedata};
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && bus.address == ADDR_PAYLOAD && !w_busy) r_buf[r_wr_ptr] <= bus.writedata;
  end

  always_comb begin
    w_rdata = '0;
    if (bus.address < ADDR_HDR_END) begin
      w_rdata = r_hdr[bus.address[3:0]];
    end else begin
      case (bus.address)
        ADDR_IFG:    w_rdata = r_ifg;
        ADDR_CTRL:   w_rdata = {7'b0, r_en};
        ADDR_TARGET: w_rdata = r_target;
        ADDR_CKSUM0: w_rdata = r_cksum[7:0];
        ADDR_CKSUM1: w_rdata = r_cksum[15:8];
        ADDR_CKSUM2: w_rdata = r_cksum[23:16];
        ADDR_CKSUM3: w_rdata = r_cksum[31:24];
        ADDR_FRAMES: w_rdata = r_frames;
        ADDR_STATUS: w_rdata = {5'b0, r_wr_err, r_done, w_busy};
        default:     w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_readdata <= '0;
    else       r_readdata <= w_rd ? w_rdata : '0;
  end
endmodule

// File: tb/tb_frame_generator_param.sv
// Directed + randomized bench for frame_generator_param (DATA_W 16 and 32 instances)
// against a byte-list frame model.
`timescale 1ns/1ps
module tb_frame_generator_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_generator_param_if #(.DATA_W(16)) ifa ();
  frame_generator_param_if #(.DATA_W(32)) ifb ();

  frame_generator_param #(.DATA_W(16), .PAYLOAD_DEPTH(128)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  frame_generator_param #(.DATA_W(32), .PAYLOAD_DEPTH(128)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  int errors = 0;
  int checks = 0;

  logic [7:0]  m_hdr [16];
  logic [7:0]  m_buf [128];
  int          m_wr_ptr = 0;
  logic [31:0] m_cksum = '0;
  logic [7:0]  frame_q [$];
  logic [79:0] last_beat;
  int          idle_got;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] obs(input bit sel);
    if (sel) return {ifb.egress_port_tvalid, ifb.egress_port_tlast, 6'b0, 4'b0,
                     ifb.egress_port_tkeep, 32'b0, ifb.egress_port_tdata};
    return {ifa.egress_port_tvalid, ifa.egress_port_tlast, 6'b0, 6'b0,
            ifa.egress_port_tkeep, 48'b0, ifa.egress_port_tdata};
  endfunction

  // Frame = 7xAA, AB, dst, src, LEN hi, LEN lo, type, payload[i % 128].
  function automatic void build_frame();
    int len;
    frame_q.delete();
    for (int i = 0; i < 7; i++) frame_q.push_back(8'hAA);
    frame_q.push_back(8'hAB);
    for (int i = 0; i < 12; i++) frame_q.push_back(m_hdr[i]);
    frame_q.push_back(m_hdr[13]);
    frame_q.push_back(m_hdr[12]);
    frame_q.push_back(m_hdr[14]);
    frame_q.push_back(m_hdr[15]);
    len = int'({m_hdr[13], m_hdr[12]});
    for (int i = 0; i < len; i++) frame_q.push_back(m_buf[i % 128]);
  endfunction

  function automatic logic [79:0] exp_beat(input int j, input int bpb, input int nb);
    logic [63:0] d;
    logic [7:0]  k;
    d = '0;
    k = '0;
    for (int i = 0; i < bpb; i++) begin
      d = d << 8;
      k = k << 1;
      if (j * bpb + i < frame_q.size()) begin
        d[7:0] = frame_q[j * bpb + i];
        k[0]   = 1'b1;
      end
    end
    return {1'b1, (j == nb - 1), 6'b0, k, d};
  endfunction

  task automatic set_ready(input bit sel, input logic v);
    if (sel) ifb.egress_port_tready = v;
    else     ifa.egress_port_tready = v;
  endtask

  task automatic wr(input bit sel, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    if (sel) begin
      ifb.chipselect = 1'b1; ifb.write = 1'b1; ifb.address = a; ifb.writedata = d;
    end else begin
      ifa.chipselect = 1'b1; ifa.write = 1'b1; ifa.address = a; ifa.writedata = d;
    end
    @(negedge clk);
    ifa.chipselect = 1'b0; ifa.write = 1'b0;
    ifb.chipselect = 1'b0; ifb.write = 1'b0;
  endtask

  task automatic rd_chk(input bit sel, input logic [7:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    @(negedge clk);
    if (sel) begin ifb.chipselect = 1'b1; ifb.read = 1'b1; ifb.address = a; end
    else     begin ifa.chipselect = 1'b1; ifa.read = 1'b1; ifa.address = a; end
    @(negedge clk);
    d = sel ? ifb.readdata : ifa.readdata;
    ifa.chipselect = 1'b0; ifa.read = 1'b0;
    ifb.chipselect = 1'b0; ifb.read = 1'b0;
    chk(tag, 80'(d), 80'(exp));
  endtask

  task automatic hdr(input bit sel, input int a, input logic [7:0] d);
    wr(sel, 8'(a), d);
    m_hdr[a] = d;
  endtask

  task automatic pay(input bit sel, input logic [7:0] d);
    wr(sel, 8'h13, d);
    m_buf[m_wr_ptr] = d;
    m_wr_ptr = (m_wr_ptr + 1) % 128;
    m_cksum += 32'(d);
  endtask

  task automatic ptr_clr(input bit sel);
    wr(sel, 8'h11, 8'h02);
    m_wr_ptr = 0;
    m_cksum  = '0;
  endtask

  task automatic cksum_chk(input bit sel, input string tag);
    for (int i = 0; i < 4; i++)
      rd_chk(sel, 8'(8'h14 + i), 8'(m_cksum >> (8 * i)), $sformatf("%s_cksum%0d", tag, i));
  endtask

  // mode 0: always ready, 1: toggling, 2: random. inj_at: beat count after which a
  // dst0 write and a payload write are issued mid-frame (DUT A only).
  task automatic recv(input bit sel, input int mode, input int inj_at, input string tag);
    int bpb, nb, got, cyc, inj, idle;
    bit stalled, rdy;
    logic [79:0] held, cur;
    bpb = sel ? 4 : 2;
    nb = (frame_q.size() + bpb - 1) / bpb;
    got = 0; cyc = 0; inj = 0; idle = 0; stalled = 1'b0; held = '0;
    while (got < nb && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      set_ready(sel, rdy);
      if (inj == 1) begin
        ifa.chipselect = 1'b1; ifa.write = 1'b1; ifa.address = 8'h00; ifa.writedata = 8'h5A;
        inj = 2;
      end else if (inj == 2) begin
        ifa.address = 8'h13; ifa.writedata = 8'h99;
        inj = 3;
      end else if (inj == 3) begin
        ifa.chipselect = 1'b0; ifa.write = 1'b0;
        inj = 0;
      end
      cur = obs(sel);
      if (stalled) chk($sformatf("%s_stall", tag), cur, held);
      stalled = 1'b0;
      if (cur[79]) begin
        if (rdy) begin
          chk($sformatf("%s_beat%0d", tag, got), cur, exp_beat(got, bpb, nb));
          last_beat = cur;
          got++;
          if (got == inj_at) inj = 1;
        end else begin
          stalled = 1'b1;
          held = cur;
        end
      end else if (got == 0) begin
        idle++;
      end
    end
    chk($sformatf("%s_nbeats", tag), 80'(got), 80'(nb));
    idle_got = idle;
  endtask

  initial begin
    int len, vcnt;
    ifa.chipselect = 1'b0; ifa.write = 1'b0; ifa.read = 1'b0; ifa.address = '0;
    ifa.writedata = '0; ifa.egress_port_tready = 1'b0;
    ifb.chipselect = 1'b0; ifb.write = 1'b0; ifb.read = 1'b0; ifb.address = '0;
    ifb.writedata = '0; ifb.egress_port_tready = 1'b0;
    for (int i = 0; i < 16; i++) m_hdr[i] = '0;
    for (int i = 0; i < 128; i++) m_buf[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_outputs", obs(0), '0);
    chk("rst_readdata", 80'(ifa.readdata), '0);
    reset = 1'b0;
    rd_chk(0, 8'h19, 8'h00, "rst_status");
    rd_chk(0, 8'h18, 8'h00, "rst_frames");

    // 1: 16-bit, LEN=4, one frame
    for (int i = 0; i < 6; i++) hdr(0, i, 8'(8'h01 + i));
    for (int i = 0; i < 6; i++) hdr(0, 6 + i, 8'(8'h11 + i));
    hdr(0, 12, 8'd4); hdr(0, 13, 8'd0); hdr(0, 14, 8'h88); hdr(0, 15, 8'hB5);
    pay(0, 8'h11); pay(0, 8'h22); pay(0, 8'h33); pay(0, 8'h44);
    wr(0, 8'h12, 8'd1);
    wr(0, 8'h11, 8'h01);
    build_frame();
    recv(0, 0, -1, "t1");
    chk("t1_last_data", 80'(last_beat[63:0]), 80'(16'h3344));
    chk("t1_last_keep", 80'(last_beat[71:64]), 80'(2'b11));
    cksum_chk(0, "t1");
    rd_chk(0, 8'h19, 8'h02, "t1_status");

    // 2: LEN=5, partial last beat
    ptr_clr(0);
    for (int i = 1; i <= 5; i++) pay(0, 8'(8'h11 * i));
    hdr(0, 12, 8'd5);
    wr(0, 8'h11, 8'h01);
    build_frame();
    recv(0, 0, -1, "t2");
    chk("t2_last", {last_beat[78], last_beat[71:64], last_beat[63:0]},
        {1'b1, 8'h02, 64'h5500});
    cksum_chk(0, "t2");

    // 3: random LEN/payload/type under toggling and random backpressure
    len = $urandom_range(1, 40);
    ptr_clr(0);
    for (int i = 0; i < len; i++) pay(0, 8'($urandom));
    hdr(0, 12, 8'(len)); hdr(0, 14, 8'($urandom)); hdr(0, 15, 8'($urandom));
    build_frame();
    wr(0, 8'h11, 8'h01);
    recv(0, 1, -1, "t3_toggle");
    wr(0, 8'h11, 8'h01);
    recv(0, 2, -1, "t3_random");
    cksum_chk(0, "t3");

    // 4: target 3, IFG 5
    wr(0, 8'h11, 8'h04);
    wr(0, 8'h12, 8'd3);
    wr(0, 8'h10, 8'd5);
    wr(0, 8'h11, 8'h01);
    recv(0, 2, -1, "t4_f1");
    recv(0, 2, -1, "t4_f2");
    chk("t4_gap2", 80'(idle_got >= 5), 80'(1));
    recv(0, 0, -1, "t4_f3");
    chk("t4_gap3", 80'(idle_got >= 5), 80'(1));
    set_ready(0, 1'b1);
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifa.egress_port_tvalid) vcnt++;
    end
    chk("t4_no_extra_frame", 80'(vcnt), 80'(0));
    rd_chk(0, 8'h19, 8'h02, "t4_status");
    rd_chk(0, 8'h18, 8'd3, "t4_frames");
    rd_chk(0, 8'h11, 8'h00, "t4_ctrl");

    // 5: mid-frame dst / payload writes
    wr(0, 8'h12, 8'd2);
    wr(0, 8'h10, 8'd2);
    wr(0, 8'h11, 8'h01);
    build_frame();
    recv(0, 0, 3, "t5_f1");
    m_hdr[0] = 8'h5A;
    build_frame();
    recv(0, 0, -1, "t5_f2");
    rd_chk(0, 8'h19, 8'h06, "t5_status");
    rd_chk(0, 8'h00, 8'h5A, "t5_dst0");
    rd_chk(0, 8'h18, 8'd5, "t5_frames");
    cksum_chk(0, "t5");

    // 6: reset mid-frame in continuous mode
    wr(0, 8'h12, 8'd0);
    wr(0, 8'h10, 8'd0);
    wr(0, 8'h11, 8'h01);
    set_ready(0, 1'b1);
    repeat (10) @(negedge clk);
    chk("t6_running", 80'(ifa.egress_port_tvalid), 80'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("t6_after_reset", obs(0), '0);
    reset = 1'b0;
    for (int a = 0; a <= 8'h19; a++) rd_chk(0, 8'(a), 8'h00, $sformatf("t6_rd%0h", a));
    chk("t6_no_read", 80'(ifa.readdata), '0);

    // 6b: 32-bit instance, LEN=0
    for (int i = 0; i < 16; i++) m_hdr[i] = '0;
    m_wr_ptr = 0;
    m_cksum  = '0;
    for (int i = 0; i < 6; i++) hdr(1, 6 + i, 8'(8'h11 + i));
    hdr(1, 14, 8'h88); hdr(1, 15, 8'hB5);
    wr(1, 8'h12, 8'd1);
    wr(1, 8'h11, 8'h01);
    build_frame();
    recv(1, 0, -1, "t6b");
    chk("t6b_last", {last_beat[78], last_beat[71:64], last_beat[63:0]},
        {1'b1, 8'h0F, 64'h000088B5});
    rd_chk(1, 8'h19, 8'h02, "t6b_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
